// File: rtl/toy_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: a TX FIFO feeds a start/data/stop serializer.
// Registers: TXDATA push, STATUS (full/empty/busy/overflow/count), BAUD_DIV.
module toy_uart_tx #(
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter logic [15:0] BAUD_DIV_RST = 16'd867
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [9:0]  addr,
  output logic [31:0] rd_data,
  input  logic [31:0] wr_data,
  input  logic [3:0]  wr_byte_en,
  input  logic        wr_en,
  output logic        txd,
  output logic        tx_idle
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_BAUD   = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // FIFO storage and bookkeeping
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_ovf;
  logic [15:0]   r_baud;
  logic [31:0]   r_rd_data;
  logic          r_tx_idle;

  // Serializer
  state_t        r_state;
  logic [15:0]   r_baud_cnt;
  logic [15:0]   r_frame_div;
  logic [7:0]    r_shift;
  logic [2:0]    r_bit_idx;
  logic          r_txd;

  logic [1:0]    w_sel;
  logic          w_wr;
  logic          w_rd;
  logic          w_push_req;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_baud_done;
  logic          w_idle_nxt;
  logic [CW-1:0] w_count_nxt;
  logic [7:0]    w_head;
  logic [3:0]    w_cnt_sat;
  logic [31:0]   w_status;
  logic [31:0]   w_rd_val;
  logic          w_unused;

  assign w_sel       = addr[3:2];
  assign w_wr        = en & wr_en;
  assign w_rd        = en & ~wr_en;
  assign w_push_req  = w_wr && (w_sel == REG_TXDATA) && wr_byte_en[0];
  assign w_full      = (r_count == CW'(FIFO_DEPTH));
  assign w_empty     = (r_count == '0);
  assign w_push      = w_push_req & ~w_full;
  assign w_baud_done = (r_baud_cnt == r_frame_div);
  assign w_head      = r_mem[r_rd_ptr];

  // Pop on IDLE with data, or at the end of STOP for a gapless next frame
  assign w_pop = ~w_empty &&
                 ((r_state == S_IDLE) || ((r_state == S_STOP) && w_baud_done));

  assign w_idle_nxt = w_empty &&
                      ((r_state == S_IDLE) || ((r_state == S_STOP) && w_baud_done));

  assign w_unused = ^{addr[9:4], addr[1:0], wr_data[31:16], wr_byte_en[3:2]};

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_comb begin
    w_cnt_sat = 4'(r_count);
    if (32'(r_count) > 32'd15) begin
      w_cnt_sat = 4'd15;
    end
  end

  assign w_status = {24'd0, w_cnt_sat, r_ovf, (r_state != S_IDLE), w_empty, w_full};

  always_comb begin
    w_rd_val = 32'd0;
    case (w_sel)
      REG_STATUS: w_rd_val = w_status;
      REG_BAUD:   w_rd_val = {16'd0, r_baud};
      default:    w_rd_val = 32'd0;
    endcase
  end

  // FIFO data array needs no reset; validity is tracked by the pointers
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wr_data[7:0];
    end
  end

  // Bus-side registers, FIFO pointers and status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_ovf     <= 1'b0;
      r_baud    <= BAUD_DIV_RST;
      r_rd_data <= 32'd0;
      r_tx_idle <= 1'b1;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count   <= w_count_nxt;
      r_tx_idle <= w_idle_nxt && (w_count_nxt == '0);
      if (w_push_req && w_full) begin
        r_ovf <= 1'b1;
      end else if (w_wr && (w_sel == REG_STATUS) && wr_byte_en[0] && wr_data[3]) begin
        r_ovf <= 1'b0;
      end
      if (w_wr && (w_sel == REG_BAUD)) begin
        if (wr_byte_en[0]) r_baud[7:0]  <= wr_data[7:0];
        if (wr_byte_en[1]) r_baud[15:8] <= wr_data[15:8];
      end
      if (w_rd) begin
        r_rd_data <= w_rd_val;
      end
    end
  end

  // TX frame FSM; the divider is latched per frame so BAUD_DIV writes apply next frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_txd       <= 1'b1;
      r_baud_cnt  <= 16'd0;
      r_frame_div <= 16'd0;
      r_shift     <= 8'd0;
      r_bit_idx   <= 3'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_shift     <= w_head;
            r_frame_div <= r_baud;
            r_baud_cnt  <= 16'd0;
            r_txd       <= 1'b0;
            r_state     <= S_START;
          end
        end
        S_START: begin
          if (w_baud_done) begin
            r_baud_cnt <= 16'd0;
            r_bit_idx  <= 3'd0;
            r_txd      <= r_shift[0];
            r_state    <= S_DATA;
          end else begin
            r_baud_cnt <= r_baud_cnt + 16'd1;
          end
        end
        S_DATA: begin
          if (w_baud_done) begin
            r_baud_cnt <= 16'd0;
            if (r_bit_idx == 3'd7) begin
              r_txd   <= 1'b1;
              r_state <= S_STOP;
            end else begin
              r_shift   <= r_shift >> 1;
              r_txd     <= r_shift[1];
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + 16'd1;
          end
        end
        S_STOP: begin
          if (w_baud_done) begin
            r_baud_cnt <= 16'd0;
            if (w_pop) begin
              r_shift     <= w_head;
              r_frame_div <= r_baud;
              r_txd       <= 1'b0;
              r_state     <= S_START;
            end else begin
              r_txd   <= 1'b1;
              r_state <= S_IDLE;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + 16'd1;
          end
        end
        default: begin
          r_txd   <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign txd     = r_txd;
  assign tx_idle = r_tx_idle;
  assign rd_data = r_rd_data;

endmodule

// File: tb/tb_toy_uart_tx.sv
// Bench for toy_uart_tx: directed scenarios plus random bus traffic, compared
// every cycle against a frame-level model (queue of bytes + elapsed-time arithmetic).
module tb_toy_uart_tx;

  localparam int unsigned DEPTH    = 8;
  localparam logic [15:0] BAUD_RST = 16'd867;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0;
  logic [9:0]  addr = '0;
  logic [31:0] rd_data;
  logic [31:0] wr_data = '0;
  logic [3:0]  wr_byte_en = '0;
  logic        wr_en = 1'b0;
  logic        txd;
  logic        tx_idle;

  always #5 clk = ~clk;

  toy_uart_tx #(
    .FIFO_DEPTH  (DEPTH),
    .BAUD_DIV_RST(BAUD_RST)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .addr      (addr),
    .rd_data   (rd_data),
    .wr_data   (wr_data),
    .wr_byte_en(wr_byte_en),
    .wr_en     (wr_en),
    .txd       (txd),
    .tx_idle   (tx_idle)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: bytes waiting, current frame as a 10-bit pattern, time into frame
  logic [7:0]  m_q[$];
  logic        m_ovf;
  logic [15:0] m_baud;
  logic        m_busy;
  logic [9:0]  m_frame;
  int          m_bitlen;
  int          m_el;
  logic [31:0] m_rd;

  task automatic model_reset();
    m_q.delete();
    m_ovf    = 1'b0;
    m_baud   = BAUD_RST;
    m_busy   = 1'b0;
    m_frame  = 10'h3FF;
    m_bitlen = 1;
    m_el     = 0;
    m_rd     = 32'd0;
  endtask

  function automatic logic [31:0] model_reg(input logic [1:0] sel);
    int c;
    c = m_q.size();
    case (sel)
      2'd1: return {24'd0, 4'((c > 15) ? 15 : c), m_ovf, m_busy, 1'(c == 0), 1'(c == DEPTH)};
      2'd2: return {16'd0, m_baud};
      default: return 32'd0;
    endcase
  endfunction

  task automatic start_frame();
    logic [7:0] b;
    b = m_q.pop_front();
    m_frame  = {1'b1, b, 1'b0};
    m_bitlen = int'(m_baud) + 1;
    m_el     = 0;
    m_busy   = 1'b1;
  endtask

  // One clock edge of the model, using the inputs held across that edge
  task automatic model_step();
    int c;
    logic [1:0] sel;
    c   = m_q.size();
    sel = addr[3:2];
    if (en && !wr_en) m_rd = model_reg(sel);
    if (m_busy) begin
      m_el++;
      if (m_el == 10 * m_bitlen) begin
        if (c > 0) start_frame();
        else m_busy = 1'b0;
      end
    end else if (c > 0) begin
      start_frame();
    end
    if (en && wr_en) begin
      case (sel)
        2'd0: if (wr_byte_en[0]) begin
          if (c == DEPTH) m_ovf = 1'b1;
          else m_q.push_back(wr_data[7:0]);
        end
        2'd1: if (wr_byte_en[0] && wr_data[3]) m_ovf = 1'b0;
        2'd2: begin
          if (wr_byte_en[0]) m_baud[7:0]  = wr_data[7:0];
          if (wr_byte_en[1]) m_baud[15:8] = wr_data[15:8];
        end
        default: ;
      endcase
    end
  endtask

  task automatic check_outputs();
    logic exp_txd;
    exp_txd = m_busy ? m_frame[m_el / m_bitlen] : 1'b1;
    check("txd", 32'(txd), 32'(exp_txd));
    check("tx_idle", 32'(tx_idle), 32'(!m_busy && (m_q.size() == 0)));
    check("rd_data", rd_data, m_rd);
  endtask

  task automatic cyc(input logic t_en, input logic t_we, input logic [9:0] t_a,
                     input logic [31:0] t_d, input logic [3:0] t_be);
    en = t_en; wr_en = t_we; addr = t_a; wr_data = t_d; wr_byte_en = t_be;
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'($urandom), 10'($urandom), $urandom, 4'($urandom));
  endtask

  task automatic wr(input logic [1:0] sel, input logic [31:0] d, input logic [3:0] be);
    cyc(1'b1, 1'b1, {6'd0, sel, 2'd0}, d, be);
  endtask

  task automatic rd(input logic [1:0] sel);
    cyc(1'b1, 1'b0, {6'd0, sel, 2'd0}, 32'd0, 4'd0);
  endtask

  initial begin
    model_reset();
    #1 rst_n = 1'b0;
    #11 check_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    // Single frame 0xA5 at 4 clocks per bit
    wr(2'd2, 32'd3, 4'b0011);
    wr(2'd0, 32'hA5, 4'b0001);
    idle(44);
    rd(2'd1);
    rd(2'd2);

    // Three back-to-back frames at 1 clock per bit, status polled every cycle
    wr(2'd2, 32'd0, 4'b0011);
    wr(2'd0, 32'h3C, 4'b0001);
    wr(2'd0, 32'hC3, 4'b0001);
    wr(2'd0, 32'h81, 4'b0001);
    for (int i = 0; i < 34; i++) rd(2'd1);

    // Overflow while a frame runs, sticky clear, mid-frame divider change
    wr(2'd2, 32'd5, 4'b0011);
    wr(2'd0, 32'h11, 4'b0001);
    idle(3);
    for (int i = 0; i < 9; i++) wr(2'd0, 32'(8'h20 + i), 4'b0001);
    rd(2'd1);
    wr(2'd1, 32'h8, 4'b0001);
    rd(2'd1);
    wr(2'd2, 32'h0001, 4'b0011);
    idle(600);
    wr(2'd2, 32'h1200, 4'b0010);
    rd(2'd2);
    wr(2'd2, 32'h0001, 4'b0011);

    // Reserved and write-only reads, TXDATA write without lane 0
    rd(2'd3);
    rd(2'd0);
    wr(2'd0, 32'h5A5A5A5A, 4'b1110);
    wr(2'd3, 32'hFFFFFFFF, 4'b1111);
    idle(2);
    rd(2'd1);

    // Asynchronous reset in the middle of the data bits
    wr(2'd0, 32'h96, 4'b0001);
    idle(9);
    rst_n = 1'b0;
    model_reset();
    #1 check_outputs();
    @(negedge clk);
    check_outputs();
    rst_n = 1'b1;
    rd(2'd1);
    rd(2'd2);
    idle(40);

    // Random bus traffic with short dividers
    wr(2'd2, 32'd1, 4'b0011);
    for (int i = 0; i < 5000; i++) begin
      int r;
      logic [9:0] a;
      r = int'($urandom_range(0, 99));
      a = 10'($urandom);
      if (r < 12)      cyc(1'b1, 1'b1, {a[9:4], 2'd0, a[1:0]}, $urandom, 4'($urandom));
      else if (r < 20) cyc(1'b1, 1'b0, {a[9:4], 2'd1, a[1:0]}, $urandom, 4'($urandom));
      else if (r < 24) cyc(1'b1, 1'b0, {a[9:4], 2'd2, a[1:0]}, $urandom, 4'($urandom));
      else if (r < 26) cyc(1'b1, 1'b1, {a[9:4], 2'd2, a[1:0]},
                           {16'($urandom), 8'd0, 8'($urandom_range(0, 4))}, 4'($urandom));
      else if (r < 28) cyc(1'b1, 1'b1, {a[9:4], 2'd1, a[1:0]}, $urandom, 4'($urandom));
      else if (r < 30) cyc(1'b1, 1'($urandom), {a[9:4], 2'd3, a[1:0]}, $urandom, 4'($urandom));
      else if (r < 33) cyc(1'b1, 1'b0, {a[9:4], 2'd0, a[1:0]}, $urandom, 4'($urandom));
      else             cyc(1'b0, 1'($urandom), a, $urandom, 4'($urandom));
    end
    idle(200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/toy_uart_tx.md
# toy_uart_tx

Synthesizable memory-mapped UART transmitter for toy_soc, on the same device-bus slot as the simulation UART print model. The core writes bytes to a TX data register. The bytes queue in a small FIFO and are serialized onto `txd` as 8N1 frames, LSB first, at a programmable baud rate. Status and baud-divider registers are readable so firmware can poll before writing.

## Interface
- `FIFO_DEPTH`, default 8: TX FIFO entries. Must be a power of two and at least 2.
- `BAUD_DIV_RST`, default 16'd867: reset value of BAUD_DIV. Each bit lasts BAUD_DIV+1 clocks.
- `clk`  in  1  system clock, single clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  slave select for this access.
- `addr`  in  10  byte address; decoded on `addr[3:2]`, other bits ignored.
- `rd_data`  out  32  read data, registered.
- `wr_data`  in  32  write data.
- `wr_byte_en`  in  4  byte enables.
- `wr_en`  in  1  1 = write, 0 = read (when `en`=1).
- `txd`  out  1  serial line, idle high.
- `tx_idle`  out  1  high when the FIFO is empty and the FSM is in IDLE.

## Operation
- Register map (`addr[3:2]`):
  - 0 TXDATA (write-only, reads as 0): a write with `wr_byte_en[0]`=1 pushes `wr_data[7:0]`.
  - 1 STATUS (read): bit0 full, bit1 empty, bit2 busy (FSM not IDLE), bit3 overflow (sticky), bits[7:4] FIFO count saturated to 15, other bits 0.
    - Write with `wr_byte_en[0]`=1 and `wr_data[3]`=1 clears overflow.
  - 2 BAUD_DIV (R/W, bits[15:0]): each byte lane is written independently via `wr_byte_en[1:0]`.
  - 3: reserved. Reads return 0; writes are ignored.
- Push while full: the byte is dropped and overflow is set. Fullness is evaluated before any same-cycle pop, so a push in the cycle a pop frees an entry is still dropped.
- TX FSM: IDLE → START → DATA (8 bits) → STOP.
  - IDLE: if the FIFO is non-empty, pop the head into the shift register, latch BAUD_DIV into the frame divider, drive `txd`=0, go to START.
  - Each state holds for frame-divider+1 clocks, counted by the baud counter.
  - START: then go to DATA with bit index 0; `txd` = `shift[0]`.
  - DATA: shift right each bit period. After bit 7 go to STOP with `txd`=1.
  - STOP, at end of bit period: if the FIFO is non-empty, pop and go directly to START with no idle gap; otherwise go to IDLE.
- BAUD_DIV writes mid-frame do not affect the current frame. They are used from the next frame.
- Reset (async, mid-frame included) returns all state to reset values:
  - FIFO emptied; FSM to IDLE; overflow cleared.
  - `txd`=1, `tx_idle`=1, `rd_data`=0, BAUD_DIV=`BAUD_DIV_RST`.
  - Any partial frame is truncated with `txd` high.

## Timing
- Write at edge k:
  - FIFO count increments after k.
  - If IDLE, the pop happens at edge k+1, and `txd` is low from k+1.
- Frame length is exactly 10×(BAUD_DIV+1) clocks. Back-to-back frames are contiguous.
- Read issued at edge k (`en`=1, `wr_en`=0): `rd_data` is valid after k and holds until the next read. Writes leave `rd_data` unchanged.
- STATUS read reflects state before the edge k update, i.e. it does not include a same-cycle pop.
- FIFO pointers wrap modulo `FIFO_DEPTH`. Count width is log2(`FIFO_DEPTH`)+1.
- Simultaneous push and pop when not full: count is unchanged and both take effect.

## Test plan
- Reset with BAUD_DIV=3, write 0xA5 to TXDATA at edge k → `txd` low at k+1 for 4 clocks. Then bits 1,0,1,0,0,1,0,1 at 4 clocks each, then stop high 4 clocks. `tx_idle`=1 at k+41.
- Write 3 bytes back-to-back with BAUD_DIV=0 → 30 contiguous `txd` bit clocks, no gap between frames. STATUS count reads 2, then 1, then 0 as frames start.
- Write 9 bytes with `FIFO_DEPTH`=8 while a frame is running → 9th byte dropped, STATUS bit3=1, full=1. Write STATUS with 0x8 → bit3=0.
- Write BAUD_DIV=0x0001 mid-frame at div 5 → current frame keeps 6-clock bits, next frame uses 2-clock bits. Byte-lane write of 0x12 into `wr_byte_en`=4'b0010 → BAUD_DIV=0x1201.
- Assert `rst_n`=0 mid-DATA → `txd`=1, `tx_idle`=1, STATUS reads 0x2, BAUD_DIV reads 867, no further frame emitted.
- Read reserved offset 3 and TXDATA → `rd_data`=0. A TXDATA write with `wr_byte_en`=4'b1110 pushes nothing.
